// File: rtl/mini68k_bus_pkg.sv
// Shared types for the mini68k bus arbiter: FSM states, owners and function codes.
package mini68k_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic [2:0] FC_UDATA = 3'b001;
  localparam logic [2:0] FC_UPROG = 3'b010;
  localparam logic [2:0] FC_SPROG = 3'b110;

  // Prefetch always runs in program space; only the supervisor bit follows the CPU.
  function automatic logic [2:0] if_fc(input logic sup);
    return sup ? FC_SPROG : FC_UPROG;
  endfunction

endpackage

// File: rtl/mini68k_arb_timer.sv
// Bus wait counter; expire_o flags the wait cycle that reaches TIMEOUT_CYC.
module mini68k_arb_timer #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic wait_i,
  output logic expire_o
);

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYC - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (wait_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = wait_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/mini68k_bus_arbiter.sv
// IF/D memory bus arbiter with D priority and a D streak limit.
// MINI68K_ARB_TIMEOUT_EN adds a bus-error timeout on unanswered bus cycles.
module mini68k_bus_arbiter
  import mini68k_bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_fc,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              berr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_fc,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [3:0]        streak_q, streak_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              we_q, we_d;
  logic [2:0]        fc_q, fc_d;
  logic              d_pend;
  logic              grant;
  logic              tmo;

  assign d_pend = d_rd | d_wr;

`ifdef MINI68K_ARB_TIMEOUT_EN
  logic berr_q, berr_d;

  mini68k_arb_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (grant),
    .wait_i  ((state_q == ST_BUS) && !mem_ack),
    .expire_o(tmo)
  );

  assign berr_d = (state_q == ST_BUS) && tmo;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      berr_q <= 1'b0;
    end else begin
      berr_q <= berr_d;
    end
  end

  assign berr = berr_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign tmo  = 1'b0;
  assign berr = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    streak_d   = streak_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    fc_d       = fc_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    grant      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (d_pend && ((streak_q < STREAK_MAX) || !if_req)) begin
          grant    = 1'b1;
          owner_d  = OWN_D;
          streak_d = (streak_q < STREAK_MAX) ? streak_q + 4'd1 : streak_q;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          we_d     = d_wr;
          fc_d     = d_fc;
        end else if (if_req) begin
          grant    = 1'b1;
          owner_d  = OWN_IF;
          streak_d = 4'd0;
          addr_d   = if_addr;
          wdata_d  = '0;
          we_d     = 1'b0;
          fc_d     = if_fc(d_fc[2]);
        end else begin
          streak_d = 4'd0;
        end
        if (grant) begin
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        if (mem_ack) begin
          if (owner_q == OWN_D) begin
            d_rdata_d = mem_rdata;
          end else begin
            if_rdata_d = mem_rdata;
          end
          state_d = ST_DONE;
        end else if (tmo) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      streak_q   <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      fc_q       <= FC_UPROG;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      streak_q   <= streak_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      fc_q       <= fc_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign mem_req   = (state_q == ST_BUS);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_fc    = fc_q;
  assign if_ack    = (state_q == ST_DONE) && (owner_q == OWN_IF);
  assign d_ack     = (state_q == ST_DONE) && (owner_q == OWN_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mini68k_bus_arbiter.sv
// Scoreboard bench for mini68k_bus_arbiter; expected grants are queued as requests are raised.
`timescale 1ns/1ps
module tb_mini68k_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [23:0] if_addr = '0;
  logic        if_ack;
  logic [15:0] if_rdata;
  logic        d_rd = 1'b0;
  logic        d_wr = 1'b0;
  logic [23:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic [2:0]  d_fc = '0;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        berr;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [2:0]  mem_fc;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mini68k_bus_arbiter #(
    .ADDR_W(24), .DATA_W(16), .MAX_DSTREAK(4), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_fc(d_fc),
    .d_ack(d_ack), .d_rdata(d_rdata), .berr(berr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_fc(mem_fc), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit          is_d;
    bit          we;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [2:0]  fc;
    bit          berr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  bit          cur_v = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_acks = 0;
  logic [15:0] last_d = '0;
  logic [15:0] last_if = '0;
  int          mem_lat = 0;
  bit          mem_never = 1'b0;
  bit          mem_ack_force = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp_v);
    end
  endtask

  function automatic logic [15:0] mem_model(input logic [23:0] a);
    return a[15:0] ^ 16'h4F71;
  endfunction

  task automatic push_exp(input bit is_d, input bit we, input logic [23:0] addr,
                          input logic [15:0] wdata, input logic [2:0] fc, input bit be);
    exp_t e;
    e.is_d = is_d; e.we = we; e.addr = addr; e.wdata = wdata; e.fc = fc; e.berr = be;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acks(input int n, input int bound, input string tag);
    int start;
    int c;
    start = n_acks;
    c = 0;
    while ((n_acks < start + n) && (c < bound)) begin
      tick();
      c++;
    end
    check_eq(tag, n_acks - start, n);
  endtask

  task automatic wait_req(input int bound, input string tag);
    int c;
    c = 0;
    while (!mem_req && (c < bound)) begin
      tick();
      c++;
    end
    check_eq(tag, mem_req, 1);
  endtask

  // Memory responder: acks after mem_lat wait cycles, returns mem_model(addr).
  initial begin
    int w;
    w = 0;
    forever begin
      tick();
      if (mem_ack_force) begin
        mem_ack = 1'b1;
        mem_rdata = 16'hDEAD;
      end else if (mem_req && !mem_never && (w >= mem_lat)) begin
        mem_ack = 1'b1;
        mem_rdata = mem_model(mem_addr);
        w = 0;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 16'h0000;
        if (mem_req) w++;
        else w = 0;
      end
    end
  end

  // Monitor: pops the scoreboard at each new bus cycle and checks the owner's ack.
  initial begin
    bit req_prev;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur_v = 1'b0;
        req_prev = 1'b0;
      end else begin
        if (mem_req && !req_prev) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_grant", mem_addr, 32'hFFFF_FFFF);
          end else begin
            cur = exp_q.pop_front();
            cur_v = 1'b1;
            check_eq("grant_addr", mem_addr, cur.addr);
            check_eq("grant_we", mem_we, cur.we);
            check_eq("grant_fc", mem_fc, cur.fc);
            if (cur.we) check_eq("grant_wdata", mem_wdata, cur.wdata);
          end
        end
        if (if_ack || d_ack) begin
          if (!cur_v) begin
            check_eq("spurious_ack", {if_ack, d_ack}, 0);
          end else begin
            check_eq("ack_owner", {if_ack, d_ack}, cur.is_d ? 2'b01 : 2'b10);
            check_eq("ack_berr", berr, cur.berr);
            if (cur.is_d) begin
              if (!cur.berr) last_d = mem_model(cur.addr);
              check_eq("d_rdata", d_rdata, last_d);
            end else begin
              if (!cur.berr) last_if = mem_model(cur.addr);
              check_eq("if_rdata", if_rdata, last_if);
            end
            cur_v = 1'b0;
            n_acks++;
          end
        end
        req_prev = mem_req;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int acks0;
    // Reset values
    tick(); tick();
    check_eq("rst_ctrl", {mem_req, mem_we, if_ack, d_ack, berr}, 5'b0);
    check_eq("rst_fc", mem_fc, 3'b010);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_rdata", {if_rdata, d_rdata}, 0);
    rst_n = 1'b1;
    tick();

    // 1: IF only, two wait cycles
    mem_lat = 2;
    push_exp(1'b0, 1'b0, 24'h000100, 16'h0, 3'b010, 1'b0);
    if_addr = 24'h000100; d_fc = 3'b000; if_req = 1'b1;
    tick();
    check_eq("t1_req_latency", mem_req, 1);
    wait_acks(1, 20, "t1_ack");
    if_req = 1'b0;
    check_eq("t1_if_rdata", if_rdata, 16'h4E71);
    tick(); tick();

    // 2: D write
    mem_lat = 1;
    push_exp(1'b1, 1'b1, 24'h001000, 16'hBEEF, 3'b001, 1'b0);
    d_addr = 24'h001000; d_wdata = 16'hBEEF; d_fc = 3'b001; d_wr = 1'b1;
    wait_acks(1, 20, "t2_ack");
    d_wr = 1'b0;
    check_eq("t2_req_low", mem_req, 0);
    tick(); tick();

    // 3: both held, streak limit interleaves IF every fifth grant
    mem_lat = 0;
    for (int i = 0; i < 10; i++) begin
      if ((i % 5) == 4) push_exp(1'b0, 1'b0, 24'h000200, 16'h0, 3'b110, 1'b0);
      else push_exp(1'b1, 1'b0, 24'h003000, 16'h0, 3'b101, 1'b0);
    end
    if_addr = 24'h000200; d_addr = 24'h003000; d_fc = 3'b101;
    if_req = 1'b1; d_rd = 1'b1;
    wait_acks(10, 80, "t3_acks");
    if_req = 1'b0; d_rd = 1'b0;
    check_eq("t3_queue_empty", exp_q.size(), 0);
    tick(); tick();

    // 4: simultaneous first requests, D then IF
    mem_lat = 1;
    push_exp(1'b1, 1'b0, 24'h003100, 16'h0, 3'b001, 1'b0);
    push_exp(1'b0, 1'b0, 24'h000400, 16'h0, 3'b010, 1'b0);
    if_addr = 24'h000400; d_addr = 24'h003100; d_fc = 3'b001;
    if_req = 1'b1; d_rd = 1'b1;
    wait_acks(1, 20, "t4_first");
    d_rd = 1'b0;
    wait_acks(1, 20, "t4_second");
    if_req = 1'b0;
    tick(); tick();

    // 5: reset during BUS, then a late mem_ack
    mem_never = 1'b1;
    push_exp(1'b1, 1'b0, 24'h004000, 16'h0, 3'b001, 1'b0);
    d_addr = 24'h004000; d_fc = 3'b001; d_rd = 1'b1;
    wait_req(10, "t5_req_up");
    tick();
    acks0 = n_acks;
    rst_n = 1'b0; d_rd = 1'b0;
    tick();
    check_eq("t5_req_drop", mem_req, 0);
    check_eq("t5_no_ack", {if_ack, d_ack}, 0);
    check_eq("t5_fc", mem_fc, 3'b010);
    rst_n = 1'b1; mem_ack_force = 1'b1;
    tick(); tick(); tick();
    mem_ack_force = 1'b0; mem_never = 1'b0;
    check_eq("t5_req_idle", mem_req, 0);
    tick(); tick();
    check_eq("t5_ack_count", n_acks, acks0);
    mem_lat = 0;
    push_exp(1'b0, 1'b0, 24'h000300, 16'h0, 3'b010, 1'b0);
    if_addr = 24'h000300; d_fc = 3'b000; if_req = 1'b1;
    wait_acks(1, 20, "t5_after");
    if_req = 1'b0;
    tick(); tick();

    // 6: memory never answers
    mem_never = 1'b1;
`ifdef MINI68K_ARB_TIMEOUT_EN
    push_exp(1'b1, 1'b1, 24'h005000, 16'h1234, 3'b001, 1'b1);
`else
    push_exp(1'b1, 1'b1, 24'h005000, 16'h1234, 3'b001, 1'b0);
`endif
    d_addr = 24'h005000; d_wdata = 16'h1234; d_fc = 3'b001; d_wr = 1'b1;
    wait_req(10, "t6_req_up");
    cnt = 0;
    while (mem_req && (cnt < 40)) begin
      tick();
      cnt++;
    end
`ifdef MINI68K_ARB_TIMEOUT_EN
    check_eq("t6_wait_cycles", cnt, 8);
    check_eq("t6_ack_berr", {d_ack, berr}, 2'b11);
    d_wr = 1'b0;
    tick();
    check_eq("t6_d_rdata_kept", d_rdata, last_d);
`else
    check_eq("t6_req_held", cnt, 40);
    d_wr = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`endif
    mem_never = 1'b0;
    tick(); tick();
    check_eq("t6_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
